// File: rtl/game_score_tracker_pkg.sv
// Shared types and constants for the game score tracker: FSM state encoding,
// default score width and player ID width.
package game_pkg;
  localparam int SCORE_W_DEF = 8;
  localparam int UID_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    REPORT,
    SETTLE,
    CHECK,
    DONE
  } state_t;
endpackage

// File: rtl/game_score_tracker_sat_adder.sv
// Unsigned adder that clamps at all-ones instead of wrapping; used for score updates.
module sat_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
endmodule

// File: rtl/game_score_tracker.sv
// Per-player game tracker feeding the high-score RAM controller: scores rounds,
// reports game over, requests the high-score check. Optional STREAK_BONUS_EN.
module game_score_tracker
  import game_pkg::*;
#(
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int LIVES       = 3,
  parameter int GO_HOLD     = 2,
  parameter int HS_DELAY    = 8,
  parameter int PTS_PER_WIN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic [UID_W-1:0]   user_id,
  input  logic               round_win,
  input  logic               round_fail,
  input  logic [SCORE_W-1:0] high_score,
  output logic               go_state,
  output logic               hs_check,
  output logic [SCORE_W-1:0] score_out,
  output logic [UID_W-1:0]   user_id_out,
  output logic [1:0]         lives_left,
  output logic               busy,
  output logic               new_record
);
  localparam int MAX_CNT = (GO_HOLD > HS_DELAY) ? GO_HOLD : HS_DELAY;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [SCORE_W-1:0] r_score, w_score_next, w_score_win, w_incr;
  logic [UID_W-1:0]   r_uid, w_uid_next;
  logic [1:0]         r_lives, w_lives_next;
  logic               r_new_record, w_new_record_next;
  logic               r_go, r_hs, r_busy;

`ifdef STREAK_BONUS_EN
  logic [1:0] r_streak, w_streak_inc;

  // Streak includes the win being scored, so the third consecutive win earns the bonus.
  assign w_streak_inc = (r_streak == 2'd3) ? 2'd3 : r_streak + 2'd1;
  assign w_incr = (w_streak_inc == 2'd3) ? SCORE_W'(2 * PTS_PER_WIN) : SCORE_W'(PTS_PER_WIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= 2'd0;
    end else if (r_state == IDLE && game_start) begin
      r_streak <= 2'd0;
    end else if (r_state == PLAY) begin
      if (round_fail)     r_streak <= 2'd0;
      else if (round_win) r_streak <= w_streak_inc;
    end
  end
`else
  assign w_incr = SCORE_W'(PTS_PER_WIN);
`endif

  sat_adder #(.W(SCORE_W)) u_sat_adder (
    .i_a   (r_score),
    .i_b   (w_incr),
    .o_sum (w_score_win)
  );

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt + 1'b1;
    w_score_next      = r_score;
    w_uid_next        = r_uid;
    w_lives_next      = r_lives;
    w_new_record_next = r_new_record;
    case (r_state)
      IDLE: begin
        if (game_start) begin
          w_score_next      = '0;
          w_lives_next      = LIVES[1:0];
          w_uid_next        = user_id;
          w_new_record_next = 1'b0;
          w_state_next      = PLAY;
        end
      end
      PLAY: begin
        // A fail in the same cycle as a win takes priority; the win is dropped.
        if (round_fail) begin
          w_lives_next = r_lives - 2'd1;
          if (r_lives == 2'd1) w_state_next = REPORT;
        end else if (round_win) begin
          w_score_next = w_score_win;
        end
      end
      REPORT: if (r_cnt == CNT_W'(GO_HOLD - 1))  w_state_next = SETTLE;
      SETTLE: if (r_cnt == CNT_W'(HS_DELAY - 1)) w_state_next = CHECK;
      CHECK:  w_state_next = DONE;
      DONE: begin
        w_new_record_next = (r_score > high_score);
        w_state_next      = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (w_state_next != r_state || r_state == IDLE || r_state == PLAY) w_cnt_next = '0;
  end

  // Strobes are derived from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_score      <= '0;
      r_uid        <= '0;
      r_lives      <= 2'd0;
      r_new_record <= 1'b0;
      r_go         <= 1'b0;
      r_hs         <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_score      <= w_score_next;
      r_uid        <= w_uid_next;
      r_lives      <= w_lives_next;
      r_new_record <= w_new_record_next;
      r_go         <= (w_state_next == REPORT);
      r_hs         <= (w_state_next == CHECK);
      r_busy       <= (w_state_next != IDLE);
    end
  end

  assign go_state    = r_go;
  assign hs_check    = r_hs;
  assign score_out   = r_score;
  assign user_id_out = r_uid;
  assign lives_left  = r_lives;
  assign busy        = r_busy;
  assign new_record  = r_new_record;
endmodule

// File: tb/tb_game_score_tracker.sv
// Directed testbench for game_score_tracker; expectations adapt to STREAK_BONUS_EN.
module tb_game_score_tracker;
  logic       clk = 1'b0;
  logic       rst;
  logic       game_start;
  logic [2:0] user_id;
  logic       round_win;
  logic       round_fail;
  logic [7:0] high_score;
  logic       go_state;
  logic       hs_check;
  logic [7:0] score_out;
  logic [2:0] user_id_out;
  logic [1:0] lives_left;
  logic       busy;
  logic       new_record;

  int errors = 0;
  int checks = 0;

  game_score_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .game_start  (game_start),
    .user_id     (user_id),
    .round_win   (round_win),
    .round_fail  (round_fail),
    .high_score  (high_score),
    .go_state    (go_state),
    .hs_check    (hs_check),
    .score_out   (score_out),
    .user_id_out (user_id_out),
    .lives_left  (lives_left),
    .busy        (busy),
    .new_record  (new_record)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Score after n consecutive wins from zero (1 point each; with bonus, wins 3+ give 2).
  function automatic int score_after(input int wins);
    int s;
`ifdef STREAK_BONUS_EN
    s = (wins <= 2) ? wins : 2 + 2 * (wins - 2);
`else
    s = wins;
`endif
    return (s > 255) ? 255 : s;
  endfunction

  task automatic do_start(input logic [2:0] uid);
    @(negedge clk); game_start = 1'b1; user_id = uid;
    @(negedge clk); game_start = 1'b0;
  endtask

  task automatic do_win();
    @(negedge clk); round_win = 1'b1;
    @(negedge clk); round_win = 1'b0;
  endtask

  task automatic do_fail();
    @(negedge clk); round_fail = 1'b1;
    @(negedge clk); round_fail = 1'b0;
  endtask

  task automatic do_both();
    @(negedge clk); round_win = 1'b1; round_fail = 1'b1;
    @(negedge clk); round_win = 1'b0; round_fail = 1'b0;
  endtask

  // Called at the negedge right after the terminating fail; measures the report window.
  task automatic measure_go(output int go_n, output int gap_n, output int hs_n,
                            output bit stable, output bit done_ok);
    logic [7:0] s0;
    logic [2:0] u0;
    int guard;
    s0 = score_out; u0 = user_id_out;
    stable = 1'b1; go_n = 0; gap_n = 0; hs_n = 0; guard = 0;
    while (go_state === 1'b1 && guard < 100) begin
      go_n++; guard++; @(negedge clk);
      if (score_out !== s0 || user_id_out !== u0) stable = 1'b0;
    end
    while (hs_check !== 1'b1 && guard < 100) begin
      gap_n++; guard++; @(negedge clk);
      if (score_out !== s0 || user_id_out !== u0) stable = 1'b0;
    end
    while (hs_check === 1'b1 && guard < 100) begin
      hs_n++; guard++; @(negedge clk);
    end
    while (busy === 1'b1 && guard < 100) begin
      guard++; @(negedge clk);
    end
    done_ok = (guard < 100);
  endtask

  task automatic test_reset();
    rst = 1'b0; game_start = 1'b0; user_id = 3'd0;
    round_win = 1'b0; round_fail = 1'b0; high_score = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({go_state, hs_check, busy, new_record} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {go_state, hs_check, busy, new_record});
    end
    checks++;
    if ({score_out, user_id_out, lives_left} !== 13'd0) begin
      errors++; $display("FAIL reset_data: score=%0d uid=%0d lives=%0d expected all 0", score_out, user_id_out, lives_left);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic_game();
    int go_n, gap_n, hs_n; bit stable, ok;
    high_score = 8'd10;
    do_start(3'd3);
    checks++;
    if (busy !== 1'b1 || user_id_out !== 3'd3 || lives_left !== 2'd3 || score_out !== 8'd0) begin
      errors++; $display("FAIL basic_start: busy=%b uid=%0d lives=%0d score=%0d expected 1/3/3/0", busy, user_id_out, lives_left, score_out);
    end
    repeat (4) do_win();
    checks++;
    if (score_out !== 8'(score_after(4))) begin
      errors++; $display("FAIL basic_score: got %0d expected %0d", score_out, score_after(4));
    end
    do_fail();
    checks++;
    if (lives_left !== 2'd2 || go_state !== 1'b0) begin
      errors++; $display("FAIL basic_fail1: lives=%0d go=%b expected 2/0", lives_left, go_state);
    end
    do_fail();
    do_fail();
    checks++;
    if (lives_left !== 2'd0 || go_state !== 1'b1) begin
      errors++; $display("FAIL basic_gameover: lives=%0d go=%b expected 0/1", lives_left, go_state);
    end
    measure_go(go_n, gap_n, hs_n, stable, ok);
    checks++;
    if (go_n !== 2) begin errors++; $display("FAIL basic_go_len: got %0d expected 2", go_n); end
    checks++;
    if (gap_n !== 8) begin errors++; $display("FAIL basic_hs_gap: got %0d expected 8", gap_n); end
    checks++;
    if (hs_n !== 1) begin errors++; $display("FAIL basic_hs_len: got %0d expected 1", hs_n); end
    checks++;
    if (!stable) begin errors++; $display("FAIL basic_stable: score/uid changed during report (got 0 expected 1)"); end
    checks++;
    if (!ok || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: ok=%b busy=%b expected 1/0", ok, busy); end
    checks++;
    if (new_record !== 1'b0 || score_out !== 8'(score_after(4)) || user_id_out !== 3'd3) begin
      errors++; $display("FAIL basic_final: rec=%b score=%0d uid=%0d expected 0/%0d/3", new_record, score_out, user_id_out, score_after(4));
    end
    do_win();
    checks++;
    if (score_out !== 8'(score_after(4))) begin
      errors++; $display("FAIL idle_win_ignored: got %0d expected %0d", score_out, score_after(4));
    end
    $display("test_basic_game done");
  endtask

  task automatic test_new_record();
    int go_n, gap_n, hs_n; bit stable, ok;
    high_score = 8'd4;
    do_start(3'd1);
    repeat (8) do_win();
    repeat (3) do_fail();
    measure_go(go_n, gap_n, hs_n, stable, ok);
    checks++;
    if (!ok || new_record !== 1'b1) begin
      errors++; $display("FAIL record_set: got %b expected 1 (score=%0d hs=4)", new_record, score_out);
    end
    high_score = 8'(score_after(4));
    do_start(3'd2);
    checks++;
    if (new_record !== 1'b0) begin errors++; $display("FAIL record_clear_on_start: got %b expected 0", new_record); end
    repeat (4) do_win();
    repeat (3) do_fail();
    measure_go(go_n, gap_n, hs_n, stable, ok);
    checks++;
    if (!ok || new_record !== 1'b0 || score_out !== high_score) begin
      errors++; $display("FAIL record_equal: rec=%b score=%0d expected 0/%0d", new_record, score_out, high_score);
    end
    $display("test_new_record done");
  endtask

  task automatic test_simultaneous();
    int go_n, gap_n, hs_n; bit stable, ok;
    high_score = 8'd255;
    do_start(3'd4);
    repeat (2) do_win();
    do_both();
    checks++;
    if (score_out !== 8'(score_after(2)) || lives_left !== 2'd2) begin
      errors++; $display("FAIL both_mid: score=%0d lives=%0d expected %0d/2", score_out, lives_left, score_after(2));
    end
    do_fail();
    do_both();
    checks++;
    if (score_out !== 8'(score_after(2)) || lives_left !== 2'd0 || go_state !== 1'b1) begin
      errors++; $display("FAIL both_last: score=%0d lives=%0d go=%b expected %0d/0/1", score_out, lives_left, go_state, score_after(2));
    end
    measure_go(go_n, gap_n, hs_n, stable, ok);
    checks++;
    if (!ok || go_n !== 2 || gap_n !== 8 || hs_n !== 1) begin
      errors++; $display("FAIL both_window: go=%0d gap=%0d hs=%0d expected 2/8/1", go_n, gap_n, hs_n);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_saturation();
    int go_n, gap_n, hs_n; bit stable, ok, mono;
    logic [7:0] prev;
    high_score = 8'd0;
    do_start(3'd6);
    mono = 1'b1; prev = score_out;
    for (int i = 0; i < 300; i++) begin
      do_win();
      if (score_out < prev) mono = 1'b0;
      prev = score_out;
    end
    checks++;
    if (!mono) begin errors++; $display("FAIL sat_monotonic: score decreased (got 0 expected 1)"); end
    checks++;
    if (score_out !== 8'd255) begin errors++; $display("FAIL sat_value: got %0d expected 255", score_out); end
    repeat (3) do_fail();
    measure_go(go_n, gap_n, hs_n, stable, ok);
    checks++;
    if (!ok || new_record !== 1'b1 || score_out !== 8'd255) begin
      errors++; $display("FAIL sat_final: rec=%b score=%0d expected 1/255", new_record, score_out);
    end
    $display("test_saturation done");
  endtask

  task automatic test_reset_ignored();
    int guard; bit saw_hs;
    high_score = 8'd0;
    do_start(3'd5);
    do_win();
    repeat (3) do_fail();
    do_start(3'd2);
    checks++;
    if (user_id_out !== 3'd5 || busy !== 1'b1 || score_out !== 8'd1) begin
      errors++; $display("FAIL start_ignored: uid=%0d busy=%b score=%0d expected 5/1/1", user_id_out, busy, score_out);
    end
    guard = 0;
    while (go_state === 1'b1 && guard < 20) begin guard++; @(negedge clk); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({go_state, hs_check, busy, new_record} !== 4'b0000 || {score_out, user_id_out, lives_left} !== 13'd0) begin
      errors++; $display("FAIL async_reset: flags=%b score=%0d uid=%0d lives=%0d expected all 0",
                         {go_state, hs_check, busy, new_record}, score_out, user_id_out, lives_left);
    end
    @(negedge clk); rst = 1'b1;
    saw_hs = 1'b0;
    repeat (20) begin @(negedge clk); if (hs_check !== 1'b0 || busy !== 1'b0) saw_hs = 1'b1; end
    checks++;
    if (saw_hs) begin errors++; $display("FAIL no_hs_after_reset: activity seen (got 1 expected 0)"); end
    $display("test_reset_ignored done");
  endtask

  task automatic test_streak();
    int go_n, gap_n, hs_n; bit stable, ok;
    int exp5, exp6;
`ifdef STREAK_BONUS_EN
    exp5 = 8; exp6 = 9;
`else
    exp5 = 5; exp6 = 6;
`endif
    high_score = 8'd200;
    do_start(3'd7);
    repeat (5) do_win();
    checks++;
    if (score_out !== 8'(exp5)) begin errors++; $display("FAIL streak_5wins: got %0d expected %0d", score_out, exp5); end
    do_fail();
    do_win();
    checks++;
    if (score_out !== 8'(exp6)) begin errors++; $display("FAIL streak_after_fail: got %0d expected %0d", score_out, exp6); end
    repeat (2) do_fail();
    measure_go(go_n, gap_n, hs_n, stable, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin errors++; $display("FAIL streak_end: busy=%b expected 0", busy); end
    $display("test_streak done");
  endtask

  initial begin
    test_reset();
    test_basic_game();
    test_new_record();
    test_simultaneous();
    test_saturation();
    test_reset_ignored();
    test_streak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
